// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: function opcodes, operand bundle,
// arbiter FSM states and the shift-amount width used for RV32 shifts.
package alu_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    FOP_ADD = 4'd0,
    FOP_SUB = 4'd1,
    FOP_SLL = 4'd2,
    FOP_SRL = 4'd3,
    FOP_SRA = 4'd4,
    FOP_AND = 4'd5,
    FOP_OR  = 4'd6,
    FOP_XOR = 4'd7,
    FOP_IMM = 4'd8
  } fop_t;

  typedef struct packed {
    fop_t        fop;
    logic [31:0] rda;
    logic [31:0] rdb;
    logic [31:0] imm;
    logic        imm_sel;
    logic        u;
  } alu_req_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // True for the three shift opcodes, whose operand B is trimmed to a shift amount.
  function automatic logic is_shift(fop_t f);
    return (f == FOP_SLL) || (f == FOP_SRL) || (f == FOP_SRA);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters plus one consumer and the
// ALU arbiter. The master side drives requests and rsp_ready; the arbiter is
// the slave.
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [4*NREQ-1:0]    req_fop;
  logic [32*NREQ-1:0]   req_rda;
  logic [32*NREQ-1:0]   req_rdb;
  logic [32*NREQ-1:0]   req_imm;
  logic [NREQ-1:0]      req_imm_sel;
  logic [NREQ-1:0]      req_u;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_result;
  logic                 rsp_z;
  logic                 rsp_n;
  logic                 rsp_v;

  modport master (
    output req_valid, req_fop, req_rda, req_rdb, req_imm, req_imm_sel, req_u,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_z, rsp_n, rsp_v
  );

  modport slave (
    input  req_valid, req_fop, req_rda, req_rdb, req_imm, req_imm_sel, req_u,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_z, rsp_n, rsp_v
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Single-cycle RV32-style ALU: operand B mux (register or immediate), shifts
// on a 5-bit amount, Z/N flags from the result and V for ADD/SUB only.
// Opcodes outside the defined set produce a zero result.
module alu
  import alu_pkg::*;
(
  input  alu_req_t    op_i,
  output logic [31:0] result_o,
  output logic        z_o,
  output logic        n_o,
  output logic        v_o
);

  logic [31:0]        b;
  logic [SHAMT_W-1:0] shamt;

  // Evaluate the selected function; u chooses logical vs arithmetic right shift.
  always_comb begin
    b        = op_i.imm_sel ? op_i.imm : op_i.rdb;
    shamt    = b[SHAMT_W-1:0];
    result_o = '0;
    v_o      = 1'b0;
    case (op_i.fop)
      FOP_ADD: begin
        result_o = op_i.rda + b;
        v_o      = (op_i.rda[31] == b[31]) && (result_o[31] != op_i.rda[31]);
      end
      FOP_SUB: begin
        result_o = op_i.rda - b;
        v_o      = (op_i.rda[31] != b[31]) && (result_o[31] != op_i.rda[31]);
      end
      FOP_SLL: result_o = op_i.rda << shamt;
      FOP_SRL: result_o = op_i.rda >> shamt;
      FOP_SRA: result_o = op_i.u ? (op_i.rda >> shamt) : 32'($signed(op_i.rda) >>> shamt);
      FOP_AND: result_o = op_i.rda & b;
      FOP_OR:  result_o = op_i.rda | b;
      FOP_XOR: result_o = op_i.rda ^ b;
      FOP_IMM: result_o = op_i.imm;
      default: result_o = '0;
    endcase
    z_o = (result_o == '0);
    n_o = result_o[31];
  end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: scans the valid vector starting at ptr and wrapping,
// returning a one-hot grant and the index of the first valid requester.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int j;

  // First valid requester at or after the pointer wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters. A request is
// accepted in IDLE, executed in EXEC and held in RESP until the consumer
// takes it. Define ALU_ARB_PERF_EN to add per-requester grant and wait
// counters (perf_grants, perf_wait).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_arbiter_if.slave       bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [32*NREQ-1:0] perf_grants,
  output logic [32*NREQ-1:0] perf_wait
`endif
);

  arb_state_t  state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  alu_req_t    op_q, op_d;
  alu_req_t    cand;
  logic [31:0] res_q, res_d;
  logic        z_q, z_d, n_q, n_d, v_q, v_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [31:0]     alu_res;
  logic            alu_z, alu_n, alu_v;

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  alu u_alu (
    .op_i     (op_q),
    .result_o (alu_res),
    .z_o      (alu_z),
    .n_o      (alu_n),
    .v_o      (alu_v)
  );

  // Gather the granted requester's operands and normalise them for RV32 shifts.
  always_comb begin
    cand         = '0;
    cand.fop     = fop_t'(bus.req_fop[4*int'(gnt_idx) +: 4]);
    cand.rda     = bus.req_rda[32*int'(gnt_idx) +: 32];
    cand.rdb     = bus.req_rdb[32*int'(gnt_idx) +: 32];
    cand.imm     = bus.req_imm[32*int'(gnt_idx) +: 32];
    cand.imm_sel = bus.req_imm_sel[gnt_idx];
    cand.u       = bus.req_u[gnt_idx];
    if (is_shift(cand.fop)) begin
      cand.rdb = 32'(cand.rdb[SHAMT_W-1:0]);
      cand.imm = 32'(cand.imm[SHAMT_W-1:0]);
    end
    if (cand.fop == FOP_SRA) begin
      cand.u = 1'b0;
    end
  end

  // Next-state, register updates and request acceptance for the three-phase FSM.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    op_d          = op_q;
    rsp_id_d      = rsp_id_q;
    res_d         = res_q;
    z_d           = z_q;
    n_d           = n_q;
    v_d           = v_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = grant;
        if (gnt_any) begin
          op_d    = cand;
          id_d    = gnt_idx;
          ptr_d   = IDW'((int'(gnt_idx) + 1) % NREQ);
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d    = alu_res;
        z_d      = alu_z;
        n_d      = alu_n;
        v_d      = alu_v;
        rsp_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, operand and response registers; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      op_q     <= '0;
      rsp_id_q <= '0;
      res_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      rsp_id_q <= rsp_id_d;
      res_q    <= res_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
    end
  end

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_n      = n_q;
  assign bus.rsp_v      = v_q;

`ifdef ALU_ARB_PERF_EN
  logic [32*NREQ-1:0] grants_q, wait_q;

  // Saturating per-requester counts of accepted requests and stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      wait_q   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i] && (grants_q[32*i +: 32] != 32'hFFFF_FFFF)) begin
          grants_q[32*i +: 32] <= grants_q[32*i +: 32] + 32'd1;
        end
        if (bus.req_valid[i] && !bus.req_ready[i] && (wait_q[32*i +: 32] != 32'hFFFF_FFFF)) begin
          wait_q[32*i +: 32] <= wait_q[32*i +: 32] + 32'd1;
        end
      end
    end
  end

  assign perf_grants = grants_q;
  assign perf_wait   = wait_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with two requesters: reset values,
// round-robin alternation and latency, flag cases, shift normalisation,
// response back-pressure, illegal opcode, FOP_IMM and reset mid-operation.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic [32*NREQ-1:0] perfGrants;
  logic [32*NREQ-1:0] perfWait;
`endif

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grants (perfGrants),
    .perf_wait   (perfWait)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [3:0] fop, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm,
                               input logic sel, input logic u);
    bus.req_fop[4*r +: 4]   = fop;
    bus.req_rda[32*r +: 32] = a;
    bus.req_rdb[32*r +: 32] = b;
    bus.req_imm[32*r +: 32] = imm;
    bus.req_imm_sel[r]      = sel;
    bus.req_u[r]            = u;
  endtask

  // Issue one request from requester r, check 2-cycle latency and the response.
  // With stall > 0, rsp_ready is held low for that many RESP cycles while the
  // other requester is valid, to show the response is stable and nothing is accepted.
  task automatic runOp(input string tag, input int r, input logic [3:0] fop,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic sel, input logic u, input logic [31:0] expRes,
                       input logic expZ, input logic expN, input logic expV, input int stall);
    bit got;
    int other;
    other = 1 - r;
    applyStimulus(r, fop, a, b, imm, sel, u);
    bus.rsp_ready    = (stall == 0);
    bus.req_valid[r] = 1'b1;
    #1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready[r]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checkOutput({tag, "_grantTimeout"}, 32'(bus.req_ready), 32'(1 << r));
      bus.req_valid = '0;
      return;
    end
    checkOutput({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << r));
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
    applyStimulus(r, 4'd0, ~a, ~b, ~imm, ~sel, u);
    checkOutput({tag, "_execNoValid"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_rspValid"}, 32'(bus.rsp_valid), 32'd1);
    checkOutput({tag, "_rspId"}, 32'(bus.rsp_id), 32'(r));
    checkOutput({tag, "_result"}, bus.rsp_result, expRes);
    checkOutput({tag, "_zFlag"}, 32'(bus.rsp_z), 32'(expZ));
    checkOutput({tag, "_nFlag"}, 32'(bus.rsp_n), 32'(expN));
    checkOutput({tag, "_vFlag"}, 32'(bus.rsp_v), 32'(expV));
    if (stall > 0) begin
      bus.req_valid[other] = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        checkOutput({tag, "_stallValid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({tag, "_stallResult"}, bus.rsp_result, expRes);
        checkOutput({tag, "_stallZ"}, 32'(bus.rsp_z), 32'(expZ));
        checkOutput({tag, "_stallReady"}, 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    checkOutput({tag, "_rspDone"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  // Directed sequence.
  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.req_fop     = '0;
    bus.req_rda     = '0;
    bus.req_rdb     = '0;
    bus.req_imm     = '0;
    bus.req_imm_sel = '0;
    bus.req_u       = '0;
    bus.rsp_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rstRspId", 32'(bus.rsp_id), 32'd0);
    checkOutput("rstResult", bus.rsp_result, 32'd0);
    checkOutput("rstFlags", {29'd0, bus.rsp_z, bus.rsp_n, bus.rsp_v}, 32'd0);
    checkOutput("rstReqReady", 32'(bus.req_ready), 32'd0);

    // Both requesters valid from reset: accepts at cycles 0,3,6,9 alternating 0,1.
    applyStimulus(0, FOP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    applyStimulus(1, FOP_SUB, 32'd10, 32'd3, 32'd0, 1'b0, 1'b0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    rst           = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (cyc % 3 == 0) begin
        checkOutput($sformatf("altReady%0d", cyc), 32'(bus.req_ready), 32'(1 << ((cyc / 3) % 2)));
      end else begin
        checkOutput($sformatf("altReady%0d", cyc), 32'(bus.req_ready), 32'd0);
      end
      if (cyc % 3 == 2) begin
        checkOutput($sformatf("altRspValid%0d", cyc), 32'(bus.rsp_valid), 32'd1);
        checkOutput($sformatf("altRspId%0d", cyc), 32'(bus.rsp_id), 32'((cyc / 3) % 2));
        checkOutput($sformatf("altResult%0d", cyc), bus.rsp_result, ((cyc / 3) % 2 == 1) ? 32'd7 : 32'd3);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;

    runOp("addOvf", 0, FOP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0,
          32'h8000_0000, 1'b0, 1'b1, 1'b1, 0);
    runOp("sraMask", 1, FOP_SRA, 32'hC000_0000, 32'd0, 32'h26, 1'b1, 1'b1,
          32'hFF00_0000, 1'b0, 1'b1, 1'b0, 0);
    runOp("subStall", 0, FOP_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0,
          32'd0, 1'b1, 1'b0, 1'b0, 5);
    runOp("illegalFop", 1, 4'd12, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0,
          32'd0, 1'b1, 1'b0, 1'b0, 0);
    runOp("fopImm", 0, FOP_IMM, 32'd0, 32'h1234, 32'hABCD, 1'b0, 1'b0,
          32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 0);

    // Reset while in EXEC: response is dropped and the pointer returns to 0.
    applyStimulus(0, FOP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("rstExecGrant", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst           = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstExecRspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rstExecResult", bus.rsp_result, 32'd0);
    rst           = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    checkOutput("rstExecPtr", 32'(bus.req_ready), 32'd1);
    bus.req_valid = '0;
    @(posedge clk); #1;
    checkOutput("rstExecIdle", 32'(bus.rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
